// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared state encoding, FUNC3 codes and special-case constants for the divider
package div_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10, DONE = 2'b11} state_t;
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] dvd,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] dvd_next,
  output logic        q_bit
);
  logic [32:0] t, d;
  assign t = {rem, dvd[31]};
  // rem < divisor keeps t < 2*divisor, so bit 32 of the difference is a clean borrow flag
  assign d = t - {1'b0, divisor};
  assign q_bit = ~d[32];
  assign rem_next = q_bit ? d[31:0] : t[31:0];
  assign dvd_next = {dvd[30:0], 1'b0};
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: iterative RV32M DIV/DIVU/REM/REMU controller with pipeline stall and one-cycle valid
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        valid,
  output logic [31:0] result
);
  state_t state, state_next;
  logic [31:0] rem, dvd, divisor, rem_step, dvd_step, fix_val;
  logic [4:0] count;
  logic q_bit, sel_rem, neg_q, neg_r, accept, is_signed, div_zero, overflow;
  assign accept = (state == IDLE) & start & func3[2] & ~flush;
  assign is_signed = ~func3[0];
  assign div_zero = operand2 == 32'd0;
  assign overflow = is_signed & (operand1 == INT_MIN) & (operand2 == 32'hFFFF_FFFF);
  assign busy = (state == CALC) | (state == FIX);
  assign stall = busy | accept;
  assign valid = (state == DONE) & ~flush;
  assign fix_val = sel_rem ? (neg_r ? -rem : rem) : (neg_q ? -dvd : dvd);
  div_step u_step (
    .rem(rem),
    .dvd(dvd),
    .divisor(divisor),
    .rem_next(rem_step),
    .dvd_next(dvd_step),
    .q_bit(q_bit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = accept ? ((div_zero | overflow) ? DONE : CALC) : IDLE;
      CALC: state_next = (count == 5'd0) ? FIX : CALC;
      FIX: state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end
  // dvd doubles as the quotient: dividend bits shift out the top while quotient bits enter at bit 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      dvd <= '0;
      divisor <= '0;
      count <= '0;
      sel_rem <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          sel_rem <= func3[1];
          if (div_zero) result <= func3[1] ? operand1 : DIV_BY_ZERO_Q;
          else if (overflow) result <= func3[1] ? 32'd0 : INT_MIN;
          else begin
            rem <= '0;
            dvd <= is_signed ? abs32(operand1) : operand1;
            divisor <= is_signed ? abs32(operand2) : operand2;
            neg_q <= is_signed & (operand1[31] ^ operand2[31]);
            neg_r <= is_signed & operand1[31];
            count <= 5'd31;
          end
        end
        CALC: begin
          rem <= rem_step;
          dvd <= dvd_step | {31'd0, q_bit};
          count <= count - 5'd1;
        end
        FIX: if (!flush) result <= fix_val;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer
module tb_div_sequencer;
  import div_sequencer_pkg::*;
  logic clk = 0, rst = 1, start = 0, flush = 0;
  logic [2:0] func3 = '0;
  logic [31:0] op1 = '0, op2 = '0;
  logic busy, stall, valid;
  logic [31:0] result;
  int checks = 0, errors = 0;
  div_sequencer dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .func3(func3),
    .operand1(op1),
    .operand2(op2),
    .flush(flush),
    .busy(busy),
    .stall(stall),
    .valid(valid),
    .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    int cyc, hi;
    bit got;
    @(negedge clk);
    start = 1; func3 = f3; op1 = a; op2 = b;
    #1;
    chk({tag, "_stall_c0"}, {31'd0, stall}, 32'd1);
    cyc = 0; hi = 1; got = 0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (valid) got = 1;
      else if (stall) hi++;
    end
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_stall_at_valid"}, {31'd0, stall}, 32'd0);
    chk({tag, "_stall_cycles"}, hi, lat);
    start = 0;
    @(negedge clk);
    chk({tag, "_valid_pulse"}, {31'd0, valid}, 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int nv;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 0;
    run("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 34);
    run("div_m7_2", F3_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem_m7_2", F3_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 34);
    run("rem_7_m2", F3_REM, 32'd7, -32'sd2, 32'd1, 34);
    run("divu_5_0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu_5_0", F3_REMU, 32'd5, 32'd0, 32'd5, 1);
    run("div_m5_0", F3_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run("divu_big", F3_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34);
    // flush mid-run: result must still hold 0x0FFFFFFF from the previous op
    @(negedge clk);
    start = 1; func3 = F3_DIVU; op1 = 32'd1000; op2 = 32'd3;
    repeat (10) @(negedge clk);
    chk("flush_busy_c10", {31'd0, busy}, 32'd1);
    flush = 1; start = 0;
    #1;
    chk("flush_valid_c10", {31'd0, valid}, 32'd0);
    @(negedge clk);
    flush = 0;
    #1;
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);
    chk("flush_idle_stall", {31'd0, stall}, 32'd0);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("flush_no_valid", nv, 0);
    chk("flush_result_kept", result, 32'h0FFF_FFFF);
    run("divu_9_3", F3_DIVU, 32'd9, 32'd3, 32'd3, 34);
    // flush together with start in IDLE: nothing accepted
    @(negedge clk);
    start = 1; flush = 1; func3 = F3_DIVU; op1 = 32'd8; op2 = 32'd2;
    #1;
    chk("fs_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("fs_busy", {31'd0, busy}, 32'd0);
    start = 0; flush = 0;
    // non-divide func3 ignored
    @(negedge clk);
    start = 1; func3 = 3'b000;
    #1;
    chk("nodiv_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("nodiv_busy", {31'd0, busy}, 32'd0);
    start = 0;
    // asynchronous reset mid-operation
    @(negedge clk);
    start = 1; func3 = F3_DIVU; op1 = 32'd1000; op2 = 32'd3;
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1; start = 0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 0;
    run("div_m16_4", F3_DIV, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFC, 34);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative controller for the RV32M divide instructions (DIV, DIVU, REM, REMU) in the EX stage. It latches operands on a request and runs a 32-step restoring division, one quotient bit per cycle. While it runs, it holds the pipeline through STALL, then presents a registered result with a one-cycle VALID pulse. It sits beside the ALU; the hazard unit ORs STALL into the IF/ID/EX hold logic and FLUSH comes from branch/jump resolution.

## Interface
- No parameters. Data width is fixed at 32 (RV32).
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  EX-stage divide request; held high by the pipeline until VALID
- FUNC3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; START is ignored when FUNC3[2]=0
- OPERAND1  in  32  dividend (rs1)
- OPERAND2  in  32  divisor (rs2)
- FLUSH  in  1  cancels the in-flight operation
- BUSY  out  1  high in CALC and FIX
- STALL  out  1  pipeline hold request
- VALID  out  1  RESULT valid this cycle
- RESULT  out  32  quotient or remainder, registered

## Operation
- States: IDLE, CALC, FIX, DONE. Reset forces IDLE, and clears all registers and RESULT to 0.
- IDLE, on accept (START & FUNC3[2] & ~FLUSH):
  - Latch the operation.
  - Divisor = 0: quotient = 0xFFFFFFFF, remainder = dividend. Go to DONE.
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. Go to DONE.
  - Otherwise: load magnitudes (abs for signed ops), record sign of quotient (sign1 XOR sign2) and sign of remainder (sign1), set count = 31, go to CALC.
- CALC, one restoring step per cycle:
  - rem = {rem[30:0], dvd[31]}; dvd <<= 1.
  - If rem >= divisor: rem -= divisor and the new quotient bit is 1.
  - Arithmetic is 33 bits wide to avoid overflow on the compare/subtract.
  - On count = 0, go to FIX; otherwise decrement count.
- FIX:
  - Negate quotient and/or remainder according to the recorded signs (signed ops only).
  - Select quotient for FUNC3[1]=0, remainder for FUNC3[1]=1.
  - Register the selection into RESULT and go to DONE.
- DONE: go to IDLE unconditionally.
- Outputs:
  - VALID = (state==DONE) & ~FLUSH.
  - STALL = BUSY | (state==IDLE & START & FUNC3[2] & ~FLUSH).
  - In the special-case path, RESULT is loaded at the accept edge.
- START while BUSY is ignored; the operands latched at accept are used throughout.
- FLUSH in any state:
  - Next state is IDLE.
  - No VALID is produced.
  - RESULT keeps its previous value.
- RESULT holds its value until the next load.

## Timing
- Cycle 0 is the cycle where START is sampled high in IDLE.
- Normal path: CALC in cycles 1–32, FIX in cycle 33, DONE in cycle 34.
  - VALID=1 in cycle 34 only.
  - Latency is 34 cycles.
  - STALL is high in cycles 0–33 and low in cycle 34, so the pipeline advances at the end of cycle 34.
- Special cases (div-by-zero, overflow): DONE in cycle 1; VALID in cycle 1; STALL high in cycle 0 only.
- A back-to-back request is accepted in the cycle after DONE, since the state is IDLE again.
- RESET asserted mid-operation:
  - Outputs go to 0 immediately (asynchronous).
  - The operation is lost.
  - The first accept after deassertion starts cleanly.
- FLUSH and START together in IDLE: no accept; STALL=0.

## Structure
- Shared package holds:
  - State encoding: IDLE=2'b00, CALC=2'b01, FIX=2'b10, DONE=2'b11.
  - FUNC3 constants DIV/DIVU/REM/REMU.
  - Constants DIV_BY_ZERO_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One sub-module is natural: div_step, a combinational single restoring iteration.
  - Inputs: rem, dvd, divisor.
  - Outputs: next rem, next dvd, quotient bit.
  - It is instantiated once and registered by the FSM.

## Test plan
- DIVU 100/7, START held → VALID in cycle 34, RESULT=14; repeat as REMU → 2; STALL low exactly in cycle 34.
- DIV -7/2 → RESULT=0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); REM 7/-2 → 1.
- DIVU 5/0 → VALID in cycle 1, RESULT=0xFFFFFFFF; REMU 5/0 → 5; DIV -5/0 → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → cycle 1, 0x80000000; REM → 0.
- FLUSH in cycle 10 of DIVU 1000/3 → IDLE in cycle 11, no VALID, RESULT unchanged. A new DIVU 9/3 issued afterwards → 3 after a full 34-cycle run.
- RESET pulse in cycle 20 → BUSY/STALL/VALID/RESULT = 0 immediately. Next DIV 0xFFFFFFF0/4 (signed) → 0xFFFFFFFC (-4).
